// File: rtl/kernel_equiv_seq.sv
// Sequential equivalence checker: drives stimulus vectors (exhaustive or LFSR) into a
// golden and a mapped combinational kernel and counts output disagreements.
module kernel_equiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic [14:0] lfsr_seed,
  input  logic [15:0] num_vec,
  output logic [14:0] vec_out,
  input  logic        ref_in,
  input  logic        dut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mism_cnt,
  output logic [14:0] first_fail_vec,
  output logic        first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] vec_q, vec_d;
  logic [15:0] left_q, left_d;   // vectors remaining after the current one
  logic        mode_q, mode_d;
  logic [15:0] mism_q, mism_d;
  logic [14:0] ffv_q, ffv_d;
  logic        ffok_q, ffok_d;
  logic        pass_q, pass_d;

  logic        mismatch;
  logic        last_vec;
  logic [14:0] seed_fix;
  logic [14:0] vec_next;
  logic [15:0] mism_inc;

  // An all-zero LFSR state would lock up, so it is replaced by 1.
  assign seed_fix = (lfsr_seed == 15'd0) ? 15'd1 : lfsr_seed;
  assign vec_next = mode_q ? {vec_q[13:0], vec_q[14] ^ vec_q[13]} : vec_q + 15'd1;
  assign mismatch = ref_in ^ dut_in;
  assign last_vec = (left_q == 16'd0);
  assign mism_inc = (mism_q == 16'hFFFF) ? mism_q : mism_q + 16'd1;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    vec_d   = vec_q;
    left_d  = left_q;
    mode_d  = mode_q;
    mism_d  = mism_q;
    ffv_d   = ffv_q;
    ffok_d  = ffok_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          mism_d = 16'd0;
          ffv_d  = 15'd0;
          ffok_d = 1'b0;
          if (mode) begin
            vec_d  = seed_fix;
            left_d = num_vec - 16'd1;
            if (num_vec == 16'd0) begin
              state_d = S_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            vec_d   = 15'd0;
            left_d  = 16'h7FFF;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        // The compare of the current vector is counted even when abort ends the run here.
        if (mismatch) begin
          mism_d = mism_inc;
          if (!ffok_q) begin
            ffv_d  = vec_q;
            ffok_d = 1'b1;
          end
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_vec) begin
          state_d = S_DONE;
          pass_d  = (mism_d == 16'd0);
        end else begin
          vec_d  = vec_next;
          left_d = left_q - 16'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 15'd0;
      left_q  <= 16'd0;
      mode_q  <= 1'b0;
      mism_q  <= 16'd0;
      ffv_q   <= 15'd0;
      ffok_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      vec_q   <= vec_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      mism_q  <= mism_d;
      ffv_q   <= ffv_d;
      ffok_q  <= ffok_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign mism_cnt         = mism_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffok_q;

endmodule

// File: tb/tb_kernel_equiv_seq.sv
// Bench for kernel_equiv_seq: emulates golden/mapped kernels with injectable faults and
// compares each run against a vector-list reference model.
module tb_kernel_equiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [14:0] lfsr_seed = 15'd0;
  logic [15:0] num_vec = 16'd0;
  logic [14:0] vec_out;
  logic        ref_in, dut_in;
  logic        busy, done, pass;
  logic [15:0] mism_cnt;
  logic [14:0] first_fail_vec;
  logic        first_fail_valid;

  int   fault_kind = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_pass = 1'b0;

  typedef struct {
    int          busy_cycles;
    int          done_cnt;
    int          done_at;
    int          vec_errs;
    int          exp_mism;
    logic [14:0] exp_first;
    logic        exp_valid;
  } run_res_t;

  always #5 clk = ~clk;

  kernel_equiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .lfsr_seed(lfsr_seed), .num_vec(num_vec), .vec_out(vec_out),
    .ref_in(ref_in), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .mism_cnt(mism_cnt), .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  function automatic logic golden(input logic [14:0] v);
    return (^(v & 15'h5A3C)) ^ v[0];
  endfunction

  function automatic logic fault_at(input int kind, input logic [14:0] v);
    case (kind)
      0:       return 1'b0;
      1:       return (v == 15'h1234) || (v == 15'h5000);
      2:       return 1'b1;
      default: return (int'(v) % 7) == 3;
    endcase
  endfunction

  function automatic logic [14:0] model_next(input logic m, input logic [14:0] v);
    if (m) return {v[13:0], v[14] ^ v[13]};
    return v + 15'd1;
  endfunction

  assign ref_in = golden(vec_out);
  assign dut_in = golden(vec_out) ^ fault_at(fault_kind, vec_out);

  // Issues one run, observes it, and returns observations plus model expectations.
  task automatic do_run(input logic m, input logic [14:0] seed, input logic [15:0] nv,
                        input int stop_after, input bit spam, output run_res_t r);
    logic [14:0] first_v, ev;
    int v, n_model;
    v = m ? int'(nv) : 32768;
    first_v = m ? ((seed == 15'd0) ? 15'd1 : seed) : 15'd0;
    n_model = (stop_after > 0) ? stop_after : v;
    r.exp_mism = 0; r.exp_valid = 1'b0; r.exp_first = 15'd0;
    ev = first_v;
    for (int i = 0; i < n_model; i++) begin
      if (fault_at(fault_kind, ev)) begin
        if (!r.exp_valid) r.exp_first = ev;
        r.exp_valid = 1'b1;
        r.exp_mism++;
      end
      ev = model_next(m, ev);
    end
    r.busy_cycles = 0; r.done_cnt = 0; r.done_at = -1; r.vec_errs = 0;
    ev = first_v;
    @(negedge clk);
    mode = m; lfsr_seed = seed; num_vec = nv; start = 1'b1;
    @(negedge clk);
    start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int k = 0; k < v + 4; k++) begin
      if (busy) begin
        r.busy_cycles++;
        if (vec_out !== ev) r.vec_errs++;
        ev = model_next(m, ev);
      end
      if (done) begin
        r.done_cnt++;
        if (r.done_at < 0) r.done_at = k;
      end
      if (stop_after > 0 && k >= stop_after + 2) break;
      if (r.done_at >= 0 && k > r.done_at + 1) break;
      abort = (stop_after > 0) && (k == stop_after - 1);
      start = (spam && k < v) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid} !== 50'd0) begin
      n_bad++; $display("FAIL reset_outputs: got vec=%h busy=%b done=%b pass=%b mism=%h ffv=%h ffok=%b want all 0",
        vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_lfsr_basic;
    run_res_t r;
    fault_kind = 0;
    do_run(1'b1, 15'h0001, 16'd4, 0, 1'b0, r);
    exp_pass = 1'b1;
    n_cmp++; if (r.vec_errs !== 0) begin n_bad++; $display("FAIL lfsr4_vectors: got %0d bad want 0", r.vec_errs); end
    n_cmp++; if (r.busy_cycles !== 4) begin n_bad++; $display("FAIL lfsr4_busy: got %0d want 4", r.busy_cycles); end
    n_cmp++; if (r.done_at !== 4 || r.done_cnt !== 1) begin
      n_bad++; $display("FAIL lfsr4_done: got at=%0d cnt=%0d want at=4 cnt=1", r.done_at, r.done_cnt); end
    n_cmp++; if (vec_out !== 15'h0008) begin n_bad++; $display("FAIL lfsr4_hold: got %h want 0008", vec_out); end
    n_cmp++; if ({pass, mism_cnt, first_fail_valid} !== {1'b1, 16'd0, 1'b0}) begin
      n_bad++; $display("FAIL lfsr4_result: got pass=%b mism=%h ffok=%b want 1 0 0", pass, mism_cnt, first_fail_valid); end
    do_run(1'b1, 15'h0000, 16'd3, 0, 1'b0, r);
    n_cmp++; if (r.vec_errs !== 0 || vec_out !== 15'h0004) begin
      n_bad++; $display("FAIL seed0_vectors: got %0d bad last=%h want 0 bad last=0004", r.vec_errs, vec_out); end
  endtask

  task automatic test_zero_vec;
    run_res_t r;
    fault_kind = 2;
    do_run(1'b1, 15'h2A2A, 16'd0, 0, 1'b0, r);
    exp_pass = 1'b1;
    n_cmp++; if (r.done_at !== 0 || r.done_cnt !== 1 || r.busy_cycles !== 0) begin
      n_bad++; $display("FAIL zero_vec_timing: got at=%0d cnt=%0d busy=%0d want 0 1 0", r.done_at, r.done_cnt, r.busy_cycles); end
    n_cmp++; if ({pass, mism_cnt} !== {1'b1, 16'd0}) begin
      n_bad++; $display("FAIL zero_vec_result: got pass=%b mism=%h want 1 0", pass, mism_cnt); end
  endtask

  task automatic test_lfsr_random;
    run_res_t r;
    logic [15:0] nv;
    for (int it = 0; it < 4; it++) begin
      fault_kind = 3;
      nv = 16'($urandom_range(1, 300));
      do_run(1'b1, 15'($urandom), nv, 0, 1'b1, r);
      exp_pass = (r.exp_mism == 0);
      n_cmp++; if (r.vec_errs !== 0 || r.busy_cycles !== int'(nv) || r.done_cnt !== 1) begin
        n_bad++; $display("FAIL lfsr_rand%0d_run: got bad=%0d busy=%0d done=%0d want 0 %0d 1", it, r.vec_errs, r.busy_cycles, r.done_cnt, nv); end
      n_cmp++; if ({mism_cnt, first_fail_vec, first_fail_valid, pass} !== {16'(r.exp_mism), r.exp_first, r.exp_valid, exp_pass}) begin
        n_bad++; $display("FAIL lfsr_rand%0d_result: got mism=%h ffv=%h ffok=%b pass=%b want %h %h %b %b", it,
          mism_cnt, first_fail_vec, first_fail_valid, pass, 16'(r.exp_mism), r.exp_first, r.exp_valid, exp_pass); end
    end
  endtask

  task automatic test_exhaustive_two_faults;
    run_res_t r;
    fault_kind = 1;
    do_run(1'b0, 15'h7777, 16'd9, 0, 1'b1, r);
    exp_pass = 1'b0;
    n_cmp++; if (r.vec_errs !== 0 || r.busy_cycles !== 32768) begin
      n_bad++; $display("FAIL exh2_run: got bad=%0d busy=%0d want 0 32768", r.vec_errs, r.busy_cycles); end
    n_cmp++; if (r.done_cnt !== 1 || r.done_at !== 32768) begin
      n_bad++; $display("FAIL exh2_done: got cnt=%0d at=%0d want 1 32768", r.done_cnt, r.done_at); end
    n_cmp++; if ({mism_cnt, first_fail_vec, first_fail_valid, pass} !== {16'd2, 15'h1234, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL exh2_result: got mism=%h ffv=%h ffok=%b pass=%b want 0002 1234 1 0",
        mism_cnt, first_fail_vec, first_fail_valid, pass); end
  endtask

  task automatic test_exhaustive_inverted;
    run_res_t r;
    fault_kind = 2;
    do_run(1'b0, 15'h0000, 16'd0, 0, 1'b0, r);
    exp_pass = 1'b0;
    n_cmp++; if ({mism_cnt, first_fail_vec, first_fail_valid, pass} !== {16'h8000, 15'h0000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL exh_inv_result: got mism=%h ffv=%h ffok=%b pass=%b want 8000 0000 1 0",
        mism_cnt, first_fail_vec, first_fail_valid, pass); end
  endtask

  task automatic test_abort;
    run_res_t r;
    fault_kind = 0;
    do_run(1'b1, 15'h1357, 16'd20, 0, 1'b0, r);
    exp_pass = 1'b1;
    fault_kind = 2;
    do_run(1'b0, 15'h0000, 16'd0, 100, 1'b0, r);
    n_cmp++; if (r.done_cnt !== 0 || r.busy_cycles !== 100) begin
      n_bad++; $display("FAIL abort100_run: got done=%0d busy=%0d want 0 100", r.done_cnt, r.busy_cycles); end
    n_cmp++; if ({mism_cnt, first_fail_vec, first_fail_valid, pass} !== {16'd100, 15'h0000, 1'b1, exp_pass}) begin
      n_bad++; $display("FAIL abort100_result: got mism=%h ffv=%h ffok=%b pass=%b want 0064 0000 1 %b",
        mism_cnt, first_fail_vec, first_fail_valid, pass, exp_pass); end
  endtask

  task automatic test_abort_on_last;
    run_res_t r;
    fault_kind = 2;
    do_run(1'b1, 15'h0421, 16'd5, 5, 1'b0, r);
    n_cmp++; if (r.done_cnt !== 0 || mism_cnt !== 16'(r.exp_mism) || pass !== exp_pass) begin
      n_bad++; $display("FAIL abort_last: got done=%0d mism=%h pass=%b want 0 %h %b", r.done_cnt, mism_cnt, pass, 16'(r.exp_mism), exp_pass); end
  endtask

  task automatic test_reset_mid_run;
    run_res_t r;
    fault_kind = 2;
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid} !== 50'd0) begin
      n_bad++; $display("FAIL midrun_reset: got vec=%h busy=%b done=%b pass=%b mism=%h ffv=%h ffok=%b want all 0",
        vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL midrun_idle: got busy=%b done=%b want 0 0", busy, done); end
    fault_kind = 3;
    do_run(1'b1, 15'h0BAD, 16'd60, 0, 1'b1, r);
    exp_pass = (r.exp_mism == 0);
    n_cmp++; if (r.vec_errs !== 0 || r.busy_cycles !== 60 || r.done_cnt !== 1 || mism_cnt !== 16'(r.exp_mism) || pass !== exp_pass) begin
      n_bad++; $display("FAIL post_reset_run: got bad=%0d busy=%0d done=%0d mism=%h pass=%b want 0 60 1 %h %b",
        r.vec_errs, r.busy_cycles, r.done_cnt, mism_cnt, pass, 16'(r.exp_mism), exp_pass); end
  endtask

  initial begin
    test_reset();
    test_lfsr_basic();
    test_zero_vec();
    test_lfsr_random();
    test_exhaustive_two_faults();
    test_exhaustive_inverted();
    test_abort();
    test_abort_on_last();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
